// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns the CPU datapath's simple level-held memory port into
// single-beat, full-word AXI4-Lite transactions, one outstanding at a time.
module mem_axi_bridge (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  output logic        mem_rd_ready,
  output logic [31:0] mem_rd_data,
  output logic        mem_wr_ready,
  output logic        mem_err,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        rd_ready_q, rd_ready_d;
  logic        wr_ready_q, wr_ready_d;
  logic        err_q, err_d;
  logic        misaligned;
  logic        aw_done;
  logic        w_done;

  // A misaligned request is latched like any other but its valids stay low;
  // the address/request state then sees the latched low bits and skips to DONE.
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign aw_done    = ~awvalid_q | m_awready;
  assign w_done     = ~wvalid_q | m_wready;

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    rd_ready_d = 1'b0;
    wr_ready_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_rd_en) begin
          addr_d    = mem_addr;
          arvalid_d = (mem_addr[1:0] == 2'b00);
          state_d   = RD_ADDR;
        end else if (mem_wr_en) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wr_data;
          awvalid_d = (mem_addr[1:0] == 2'b00);
          wvalid_d  = (mem_addr[1:0] == 2'b00);
          state_d   = WR_REQ;
        end
      end
      RD_ADDR: begin
        if (misaligned) begin
          rd_ready_d = 1'b1;
          err_d      = 1'b1;
          state_d    = DONE;
        end else if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          rd_data_d  = m_rdata;
          err_d      = (m_rresp != 2'b00);
          rd_ready_d = 1'b1;
          rready_d   = 1'b0;
          state_d    = DONE;
        end
      end
      WR_REQ: begin
        if (misaligned) begin
          wr_ready_d = 1'b1;
          err_d      = 1'b1;
          state_d    = DONE;
        end else begin
          awvalid_d = awvalid_q & ~m_awready;
          wvalid_d  = wvalid_q & ~m_wready;
          if (aw_done && w_done) begin
            bready_d = 1'b1;
            state_d  = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          err_d      = (m_bresp != 2'b00);
          wr_ready_d = 1'b1;
          bready_d   = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd_data_q  <= 32'h0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd_ready = rd_ready_q;
  assign mem_rd_data  = rd_data_q;
  assign mem_wr_ready = wr_ready_q;
  assign mem_err      = err_q;
  assign m_awaddr     = addr_q;
  assign m_awprot     = 3'b000;
  assign m_awvalid    = awvalid_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = 4'hF;
  assign m_wvalid     = wvalid_q;
  assign m_bready     = bready_q;
  assign m_araddr     = addr_q;
  assign m_arprot     = 3'b000;
  assign m_arvalid    = arvalid_q;
  assign m_rready     = rready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a small AXI slave responder, a handshake
// monitor, and hand-computed expectations for each scenario.
module tb_mem_axi_bridge;

  logic        clock;
  logic        reset_n;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_rd_ready, mem_wr_ready, mem_err;
  logic [31:0] mem_rd_data;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int checkCount = 0;
  int passCount  = 0;

  // Monitor counters
  int arHs = 0, awHs = 0, wHs = 0, rHs = 0, bHs = 0;
  int arvCycles = 0, overlapCycles = 0;
  logic [31:0] lastAraddr = 0, lastAwaddr = 0, lastWdata = 0;
  logic [3:0]  lastWstrb = 0;

  // Slave response values used by the zero-wait responder
  logic [31:0] slaveRdata;
  logic [1:0]  slaveRresp, slaveBresp;

  mem_axi_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .mem_wr_ready(mem_wr_ready), .mem_err(mem_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count handshakes and detect overlapping read/write activity
  always @(posedge clock) begin
    if (reset_n) begin
      if (m_arvalid && m_arready) begin arHs++; lastAraddr = m_araddr; end
      if (m_awvalid && m_awready) begin awHs++; lastAwaddr = m_awaddr; end
      if (m_wvalid && m_wready) begin wHs++; lastWdata = m_wdata; lastWstrb = m_wstrb; end
      if (m_rvalid && m_rready) rHs++;
      if (m_bvalid && m_bready) bHs++;
      if (m_arvalid) arvCycles++;
      if ((m_arvalid || m_rready) && (m_awvalid || m_wvalid || m_bready)) overlapCycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    mem_rd_en   = rd;
    mem_wr_en   = wr;
    mem_addr    = addr;
    mem_wr_data = data;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Zero-wait slave: answer every valid in the cycle it is seen, until a CPU ready pulse
  task automatic runUntil(output int cyc, output logic rdSeen, output logic wrSeen, output logic errSeen);
    cyc = 0; rdSeen = 0; wrSeen = 0; errSeen = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      cyc = i;
      m_arready = m_arvalid;
      m_awready = m_awvalid;
      m_wready  = m_wvalid;
      m_rvalid  = m_rready;
      m_bvalid  = m_bready;
      m_rdata   = slaveRdata;
      m_rresp   = slaveRresp;
      m_bresp   = slaveBresp;
      if (mem_rd_ready || mem_wr_ready) begin
        rdSeen = mem_rd_ready; wrSeen = mem_wr_ready; errSeen = mem_err;
        break;
      end
    end
    m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
    if (!(rdSeen || wrSeen)) $display("[TB] FAIL timeout: observed no ready, expected a ready pulse");
  endtask

  initial begin
    int cyc;
    logic rdS, wrS, errS;
    int ar0, aw0, w0, b0, arv0;

    reset_n = 0;
    applyStimulus(0, 0, 32'h0, 32'h0);
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    slaveRdata = 0; slaveRresp = 0; slaveBresp = 0;
    #12;
    checkOutput("reset_outputs", {mem_rd_ready, mem_wr_ready, mem_err, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'h0);
    checkOutput("reset_rd_data", mem_rd_data, 32'h0);
    checkOutput("reset_wstrb_prot", {m_wstrb, m_awprot, m_arprot}, {22'h0, 4'hF, 6'h0});
    @(negedge clock); reset_n = 1;
    tick();

    // Aligned read, zero-wait slave
    slaveRdata = 32'hDEADBEEF; slaveRresp = 2'b00;
    applyStimulus(1, 0, 32'h0000_1000, 32'h0);
    runUntil(cyc, rdS, wrS, errS);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("rd_latency", cyc, 3);
    checkOutput("rd_flags", {rdS, wrS, errS}, 32'b100);
    checkOutput("rd_data", mem_rd_data, 32'hDEADBEEF);
    checkOutput("rd_araddr", lastAraddr, 32'h0000_1000);
    tick();
    checkOutput("rd_pulse_one_cycle", {mem_rd_ready, mem_err}, 32'h0);

    // Misaligned read: no AR issued, error pulse in cycle 2, data unchanged
    arv0 = arvCycles;
    applyStimulus(1, 0, 32'h0000_1002, 32'h0);
    runUntil(cyc, rdS, wrS, errS);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("mis_rd_latency", cyc, 2);
    checkOutput("mis_rd_flags", {rdS, wrS, errS}, 32'b101);
    checkOutput("mis_rd_data_kept", mem_rd_data, 32'hDEADBEEF);
    checkOutput("mis_rd_no_arvalid", arvCycles - arv0, 0);
    tick();

    // Write with W accepted two cycles ahead of AW, B three cycles after AW
    aw0 = awHs; w0 = wHs; b0 = bHs;
    applyStimulus(0, 1, 32'h0000_2004, 32'h1234_5678);
    tick();
    checkOutput("wr_valids_on_entry", {m_awvalid, m_wvalid}, 32'b11);
    m_wready = 1;
    tick();
    m_wready = 0;
    checkOutput("wr_w_dropped", {m_awvalid, m_wvalid}, 32'b10);
    tick();
    checkOutput("wr_aw_held", {m_awvalid, m_wvalid, m_bready}, 32'b100);
    m_awready = 1;
    tick();
    m_awready = 0;
    checkOutput("wr_resp_state", {m_awvalid, m_wvalid, m_bready}, 32'b001);
    tick();
    tick();
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    checkOutput("wr_ready_pulse", {mem_wr_ready, mem_rd_ready, mem_err, m_bready}, 32'b1000);
    applyStimulus(0, 0, 32'h0, 32'h0);
    tick();
    checkOutput("wr_single_pulse", {mem_wr_ready, m_awvalid, m_wvalid, m_arvalid}, 32'h0);
    checkOutput("wr_handshakes", {awHs - aw0, wHs - w0, bHs - b0}, {32'h0, 32'h1, 32'h1, 32'h1} >> 0);
    checkOutput("wr_addr_data", lastAwaddr ^ lastWdata, 32'h0000_2004 ^ 32'h1234_5678);
    checkOutput("wr_awaddr", lastAwaddr, 32'h0000_2004);
    checkOutput("wr_wstrb", {28'h0, lastWstrb}, 32'hF);

    // Error responses
    slaveRdata = 32'hCAFE_0001; slaveRresp = 2'b10;
    applyStimulus(1, 0, 32'h0000_3000, 32'h0);
    runUntil(cyc, rdS, wrS, errS);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("rd_slverr_flags", {rdS, wrS, errS}, 32'b101);
    checkOutput("rd_slverr_data", mem_rd_data, 32'hCAFE_0001);
    tick();
    slaveRresp = 2'b00; slaveBresp = 2'b11;
    applyStimulus(0, 1, 32'h0000_3004, 32'hAAAA_5555);
    runUntil(cyc, rdS, wrS, errS);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("wr_decerr_flags", {rdS, wrS, errS}, 32'b011);
    checkOutput("wr_decerr_latency", cyc, 3);
    tick();
    slaveBresp = 2'b00;

    // Simultaneous requests: read first, then the still-held write
    ar0 = arHs; aw0 = awHs;
    slaveRdata = 32'h0BAD_F00D;
    applyStimulus(1, 1, 32'h0000_4000, 32'h7777_8888);
    runUntil(cyc, rdS, wrS, errS);
    checkOutput("both_read_first", {rdS, wrS, errS}, 32'b100);
    checkOutput("both_read_data", mem_rd_data, 32'h0BAD_F00D);
    applyStimulus(0, 1, 32'h0000_4000, 32'h7777_8888);
    runUntil(cyc, rdS, wrS, errS);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("both_write_second", {rdS, wrS, errS}, 32'b010);
    checkOutput("both_write_spacing", cyc, 4);
    checkOutput("both_hs_counts", {16'(arHs - ar0), 16'(awHs - aw0)}, {16'd1, 16'd1});
    checkOutput("both_wdata", lastWdata, 32'h7777_8888);
    checkOutput("no_overlap", overlapCycles, 0);
    tick();

    // Reset while stalled in RD_DATA
    applyStimulus(1, 0, 32'h0000_0040, 32'h0);
    tick();
    m_arready = 1;
    tick();
    m_arready = 0;
    checkOutput("pre_reset_rready", {m_rready, m_arvalid}, 32'b10);
    #2 reset_n = 0;
    #1;
    checkOutput("async_reset_outputs", {mem_rd_ready, mem_wr_ready, mem_err, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'h0);
    checkOutput("async_reset_regs", mem_rd_data | m_araddr | m_wdata, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0);
    @(negedge clock); reset_n = 1;
    tick();
    slaveRdata = 32'h55AA_55AA; slaveRresp = 2'b00;
    applyStimulus(1, 0, 32'h0000_0008, 32'h0);
    runUntil(cyc, rdS, wrS, errS);
    applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("post_reset_latency", cyc, 3);
    checkOutput("post_reset_data", mem_rd_data, 32'h55AA_55AA);
    checkOutput("post_reset_araddr", lastAraddr, 32'h0000_0008);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

AXI4-Lite master bridge that services the CPU datapath's simple memory port (`mem_rd_en`/`mem_wr_en`/`mem_addr`/`mem_wr_data` in; `mem_rd_ready`/`mem_rd_data` out) and turns each request into exactly one single-beat, full-word AXI4-Lite transaction. It is the AXI-side responder for the datapath's memory interface and sits between the CPU and the system interconnect. It handles one outstanding transaction at a time.

## Interface
- No parameters; all address and data paths are 32 bits.
- `clock` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_rd_en` in 1: read request, level-held by the CPU until `mem_rd_ready`.
- `mem_wr_en` in 1: write request, level-held by the CPU until `mem_wr_ready`.
- `mem_addr` in 32: byte address, stable while a request is held.
- `mem_wr_data` in 32: write word, stable while `mem_wr_en` is held.
- `mem_rd_ready` out 1: one-cycle pulse; read complete, `mem_rd_data` valid.
- `mem_rd_data` out 32: registered read word; holds until the next read completes.
- `mem_wr_ready` out 1: one-cycle pulse; write complete.
- `mem_err` out 1: pulses together with a ready pulse when the response is not OKAY or the address is misaligned.
- `m_awaddr` out 32, `m_awvalid` out 1, `m_awready` in 1: AXI write address channel; `m_awprot` out 3 is tied to 0.
- `m_wdata` out 32, `m_wstrb` out 4 (always 4'hF), `m_wvalid` out 1, `m_wready` in 1: AXI write data channel.
- `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1: AXI write response channel.
- `m_araddr` out 32, `m_arvalid` out 1, `m_arready` in 1: AXI read address channel; `m_arprot` out 3 is tied to 0.
- `m_rdata` in 32, `m_rresp` in 2, `m_rvalid` in 1, `m_rready` out 1: AXI read data channel.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- **IDLE**
  - `mem_rd_en` → latch `mem_addr`, go to RD_ADDR.
  - Otherwise `mem_wr_en` → latch `mem_addr` and `mem_wr_data`, go to WR_REQ.
  - Read has priority. If both enables are high, the read is served first, then the write, because the CPU still holds `mem_wr_en`.
- **Misalignment**
  - If `mem_addr[1:0] != 0`, no AXI transaction is issued; go directly to DONE with `mem_err` set.
  - A misaligned read leaves `mem_rd_data` unchanged.
- **RD_ADDR**
  - `m_arvalid`=1 with `m_araddr` = latched address.
  - On `m_arready`, drop `m_arvalid` and go to RD_DATA.
- **RD_DATA**
  - `m_rready`=1.
  - On `m_rvalid`, capture `m_rdata` into `mem_rd_data`, set err = (`m_rresp` != 2'b00), go to DONE.
- **WR_REQ**
  - `m_awvalid` and `m_wvalid` both assert on entry.
  - Each valid drops independently on its own ready; either order or the same cycle is allowed.
  - Go to WR_RESP once both channels have handshaken.
- **WR_RESP**
  - `m_bready`=1.
  - On `m_bvalid`, set err = (`m_bresp` != 0), go to DONE.
- **DONE**
  - Pulse `mem_rd_ready` or `mem_wr_ready` (per transaction type) and `mem_err` for exactly one cycle.
  - Enables are ignored in this cycle.
  - Unconditional return to IDLE.
- AXI outputs are registered.
- `m_awaddr`/`m_araddr`/`m_wdata` hold their latched values while valid is high, and are independent of CPU inputs after the latch.
- A CPU that drops its enable mid-transaction does not abort it. The transaction completes and the ready pulse is still issued.

## Timing
- **Read latency**
  - Request seen in IDLE at cycle 0; `m_arvalid` high in cycle 1.
  - With `m_arready` high in cycle 1 and `m_rvalid` high in cycle 2, `mem_rd_ready` is high in cycle 3.
  - Each slave wait cycle adds one cycle.
- **Write minimum**
  - `mem_wr_en` at cycle 0; AW and W handshake in cycle 1; `m_bvalid` in cycle 2; `mem_wr_ready` in cycle 3.
- **Back-to-back**
  - The CPU samples ready at the end of DONE and must drop or change its enable by the next edge.
  - IDLE re-samples in the cycle after DONE, so the minimum spacing is 4 cycles per transaction.
- **Reset**
  - Asserting `reset_n`=0 at any time, including mid-transaction, asynchronously forces the state to IDLE.
  - All valid, ready and `mem_*` outputs go to 0, as do `mem_rd_data`, the latched address and data registers, `m_wdata` and `mem_err`.
  - `m_wstrb` is 4'hF and `m_*prot` are 0 at all times.
  - The interconnect shares this reset, so an in-flight AXI transaction is abandoned.

## Test plan
- **Aligned read, zero-wait slave:** read at 0x0000_1000 returning 0xDEAD_BEEF/OKAY → `mem_rd_ready` pulses in cycle 3 with `mem_rd_data`=0xDEAD_BEEF and `mem_err`=0.
- **Write, skewed AW/W:** write 0x1234_5678 to 0x0000_2004, `m_wready` 2 cycles before `m_awready`, `m_bvalid` 3 cycles later → exactly one AW and one W handshake, `m_wstrb`=4'hF, a single `mem_wr_ready` pulse, and no stray valids.
- **Error responses:** read with `m_rresp`=2'b10 → `mem_rd_ready` and `mem_err` pulse together with the data captured. Write with `m_bresp`=2'b11 → `mem_wr_ready` and `mem_err` pulse together.
- **Misaligned access:** read at 0x0000_1002 → no `m_arvalid` ever asserted; `mem_rd_ready` and `mem_err` pulse in cycle 2; `mem_rd_data` unchanged.
- **Simultaneous requests:** `mem_rd_en` and `mem_wr_en` both high → read completes first, then the write is issued; the AXI monitor shows no overlapping transactions.
- **Reset mid-transaction:** pull `reset_n` low in RD_DATA with `m_rvalid` stalled → all outputs are 0 immediately. After release, a new read at 0x0000_0008 completes normally.
